// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle RV32I control path.
// Holds the FSM state encoding, ALUControl codes (also used by the ALU),
// opcode constants, datapath mux select codes and the immediate-format
// decode helper.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Coarse ALU operation requested by the FSM; refined by alu_decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_EQ  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, independent of FSM state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps the FSM's coarse ALU operation plus instruction fields
// to the 3-bit ALUControl code. Purely combinational.
//   alu_op      in  2  ADD / SUB / use funct fields
//   funct3      in  3  instruction[14:12]
//   funct7b5    in  1  instruction[30]
//   op5         in  1  instruction[5], distinguishes R-type from I-type
//   alu_control out 3  ALU operation code
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with funct7[5] subtracts; addi ignores bit 30.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath.
// Drives ALU operand selects and ALUControl, memory/IR/PC/register-file
// enables, and stalls on the memory-ready handshake.
//   clk, reset            clock and synchronous active-high reset
//   op, funct3, funct7b5  instruction fields from the IR
//   zero                  ALU zero flag (branch resolution)
//   mem_ready             memory completed the current access this cycle
//   PCWrite .. RegWrite   datapath enables and mux selects
//   ALUControl            ALU operation code
//   illegal_op            one-cycle pulse on an unsupported opcode
//   state                 current FSM state (debug)
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_r;
  state_t state_next;
  state_t cur;
  aluop_t alu_op;

  always_ff @(posedge clk) begin
    if (reset) state_r <= state_t'(RESET_STATE);
    else       state_r <= state_next;
  end

  always_comb begin
    // While reset is held the selects show the FETCH values, whatever the
    // register currently holds.
    cur        = reset ? S_FETCH : state_r;
    state_next = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALUOP_ADD;

    case (cur)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default: begin
            state_next = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        // Strobe stays up through the ready cycle so the write completes.
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = ((funct3 == 3'b000) && zero) ||
                    ((funct3 == 3'b001) && !zero);
      end
      S_JAL: begin
        // ALUOut already holds the target; ALU computes PC+4 for rd.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALUOUT;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase

    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign ImmSrc = imm_sel(op);
  assign state  = state_r;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle RV32I datapath. It drives the ALU operands and opcode (srcA/srcB mux selects, ALUControl), along with the memory, IR, PC and register-file enables. It consumes the opcode and funct fields from the IR plus the ALU `zero` flag, so it is the initiator side of the ALU control interface. It also stalls on a memory-ready handshake.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = const 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 EQ, 101 SLT
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Single state register; the next state is registered on the clk rising edge. All other outputs are combinational from state, op, funct3, funct7b5, zero and mem_ready (Moore outputs plus PCWrite/IRWrite/MemWrite gated by mem_ready or zero).
- While reset=1:
  - state <= FETCH on every clock.
  - PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced to 0.
  - The mux selects show the FETCH values.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10. Codes 11-15 are unreachable and go to FETCH.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=ADD, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while !mem_ready; otherwise go to DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ADD (computes the branch/jump target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other op → FETCH, with illegal_op=1 for this cycle
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Next is MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: AdrSrc=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE:
  - AdrSrc=1, MemWrite=1, held continuously until mem_ready.
  - On mem_ready go to FETCH. MemWrite stays high in the ready cycle.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00.
  - PCWrite = (funct3==000 & zero) | (funct3==001 & !zero). Any other funct3 gives not-taken.
  - Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. Then ALUWB (writes PC+4 to rd).
- ALU decode when ALUOp=funct:
  - funct3 000: SUB if op[5] & funct7b5, otherwise ADD.
  - funct3 010: SLT.
  - funct3 110: OR.
  - funct3 111: AND.
  - Other funct3: ADD (no trap).
- ImmSrc, from op only:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - otherwise 00
- Reset asserted mid-instruction aborts it. No write enable is asserted in the reset cycle, and execution resumes in FETCH after release.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Non-memory instructions take a fixed number of cycles, with zero wait states:
  - R-type and I-type: 4
  - BRANCH: 3
  - JAL: 4
  - lw: 5 + waits
  - sw: 4 + waits

Decomposition:
- Shared constants header (included like the other dataPath files):
  - state encodings
  - ALUControl codes, also used by ALU.v
  - opcode constants
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc select codes
- One sub-module: alu_decoder (ALUOp[1:0], funct3, funct7b5, op5 → ALUControl[2:0]), purely combinational.
- The FSM and output decode stay in multicycle_control.

Test Plan:
- Reset and fetch:
  - Drive reset=1 for 2 cycles with mem_ready=1 → state=0, and PCWrite, IRWrite, MemWrite and RegWrite all 0.
  - Release reset → same cycle IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000.
- Fetch stall: hold mem_ready=0 for 3 cycles in FETCH → state stays 0 with IRWrite=0; raise mem_ready → IRWrite=1, next state=1.
- R-type sub:
  - op=0110011, funct3=000, funct7b5=1 → states 0,1,6,8,0.
  - In state 6, ALUControl=001.
  - In state 8, RegWrite=1 and ResultSrc=00.
- Loads and stores:
  - lw (op=0000011) with 1 wait cycle in MEMREAD → states 0,1,2,3,3,4,0; ImmSrc=00.
  - sw (op=0100011) → MemWrite held high through MEMWRITE until mem_ready; ImmSrc=01.
- Branches (op=1100011):
  - beq (funct3=000), zero=1 → PCWrite=1 in state 9; zero=0 → PCWrite=0.
  - bne (funct3=001) → inverse results.
  - In state 9, ALUControl=001 and ImmSrc=10.
- Illegal opcode and mid-instruction reset:
  - op=1111111 in DECODE → illegal_op pulses for 1 cycle, next state=0.
  - Reset asserted in state 6 → next state 0, RegWrite never asserted.
